// File: rtl/dds_pkg.sv
// Shared DDS definitions: DAC sample/frame widths, control nibble and the
// SPI transmitter state encoding.
package dds_pkg;

  localparam int unsigned DAC_DATA_W  = 12;
  localparam int unsigned DAC_FRAME_W = 16;
  localparam logic [3:0]  DAC_CTRL    = 4'b0000;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD,
    GAP
  } dac_spi_state_t;

endpackage

// File: rtl/spi_tick_gen.sv
// SCK half-period timer: pulses tick_o on every CLK_DIV-th enabled cycle and
// restarts from zero whenever en_i is low.
module spi_tick_gen #(
  parameter int unsigned CLK_DIV = 3
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int unsigned W = $clog2(CLK_DIV + 1);
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dac_spi_transmitter.sv
// Serialises one 12-bit DDS sample per valid/ready handshake into a 16-bit
// SPI frame (control nibble then sample, MSB first) for the DAC.
module dac_spi_transmitter
  import dds_pkg::*;
#(
  parameter int unsigned CLK_DIV = 3,
  parameter int unsigned CS_GAP  = 4
) (
  input  logic                  sysclk,
  input  logic                  reset,
  input  logic [DAC_DATA_W-1:0] sample_data,
  input  logic                  sample_valid,
  output logic                  sample_ready,
  output logic                  spi_cs,
  output logic                  spi_sck,
  output logic                  spi_mosi,
  output logic                  frame_done
);

  localparam int unsigned GW = $clog2(CS_GAP + 1);
  // Ready rises on the last gap cycle so a held valid starts the next frame
  // exactly CS_GAP cycles after cs went high.
  localparam logic [GW-1:0] GAP_LAST = GW'((CS_GAP > 1) ? CS_GAP - 2 : 0);

  dac_spi_state_t         state_q, state_d;
  logic [DAC_FRAME_W-1:0] shreg_q, shreg_d;
  logic [3:0]             bit_q, bit_d;
  logic [GW-1:0]          gap_q, gap_d;
  logic                   cs_q, cs_d;
  logic                   sck_q, sck_d;
  logic                   mosi_q, mosi_d;
  logic                   ready_q, ready_d;
  logic                   done_q, done_d;
  logic                   tick_en;
  logic                   tick;
  logic [DAC_FRAME_W-1:0] frame_w;

  assign frame_w = {DAC_CTRL, sample_data};

  spi_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk_i  (sysclk),
    .rst_n_i(reset),
    .en_i   (tick_en),
    .tick_o (tick)
  );

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    cs_d    = cs_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    ready_d = ready_q;
    done_d  = 1'b0;
    tick_en = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sample_valid && ready_q) begin
          shreg_d = frame_w;
          bit_d   = 4'hF;
          cs_d    = 1'b0;
          sck_d   = 1'b1;
          mosi_d  = frame_w[DAC_FRAME_W-1];
          ready_d = 1'b0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        tick_en = 1'b1;
        if (tick) begin
          if (sck_q) begin
            sck_d = 1'b0;
          end else begin
            sck_d = 1'b1;
            if (bit_q == 4'd0) begin
              state_d = HOLD;
            end else begin
              bit_d   = bit_q - 4'd1;
              shreg_d = {shreg_q[DAC_FRAME_W-2:0], 1'b0};
              mosi_d  = shreg_q[DAC_FRAME_W-2];
            end
          end
        end
      end
      HOLD: begin
        tick_en = 1'b1;
        if (tick) begin
          cs_d   = 1'b1;
          done_d = 1'b1;
          mosi_d = 1'b0;
          gap_d  = '0;
          if (CS_GAP == 1) begin
            ready_d = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          ready_d = 1'b1;
          state_d = IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      cs_q    <= 1'b1;
      sck_q   <= 1'b1;
      mosi_q  <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      cs_q    <= cs_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign sample_ready = ready_q;
  assign spi_cs       = cs_q;
  assign spi_sck      = sck_q;
  assign spi_mosi     = mosi_q;
  assign frame_done   = done_q;

endmodule
